cipher_share_driver: RTL and testbench

Host-side front/back end for the byte-serial, two-share masked AES `Cipher`. It accepts a 128-bit plaintext and key and splits every byte into two Boolean shares using an internal LFSR. It streams the shares into `Cipher` with the reset/load sequence that core expects, then recombines the masked ciphertext bytes into a 128-bit result. It sits between a host/test controller and `Cipher` and is the only block that ever handles unshared data.

---
 rtl/cipher_share_pkg.sv | 16 +
 rtl/cipher_share_driver_if.sv | 30 +++
 rtl/cipher_share_driver_mask_lfsr.sv | 20 ++
 rtl/cipher_share_driver.sv | 156 +++++++++++++++
 tb/tb_cipher_share_driver.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cipher_share_pkg.sv
// Shared types and constants for the masked-AES share driver.
package cipher_share_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT    = 2'd2,
    COLLECT = 2'd3
  } state_t;

  localparam int          NUM_BYTES    = 16;
  // Galois taps for x^32+x^22+x^2+x+1 in the right-shifting form
  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

endpackage

// File: rtl/cipher_share_driver_if.sv
// Host and Cipher-facing signal bundle of cipher_share_driver.
interface cipher_share_driver_if;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         busy;
  logic         ct_valid;
  logic [127:0] ciphertext;
  logic         error;
  logic         cipher_rst;
  logic [7:0]   input1;
  logic [7:0]   input2;
  logic [7:0]   key1;
  logic [7:0]   key2;
  logic [7:0]   output1;
  logic [7:0]   output2;
  logic         Done;

  modport master (
    input  start, plaintext, key, output1, output2, Done,
    output busy, ct_valid, ciphertext, error, cipher_rst,
    output input1, input2, key1, key2
  );

  modport slave (
    output start, plaintext, key, output1, output2, Done,
    input  busy, ct_valid, ciphertext, error, cipher_rst,
    input  input1, input2, key1, key2
  );
endinterface

// File: rtl/cipher_share_driver_mask_lfsr.sv
// Free-running 32-bit Galois LFSR supplying the share masks.
module mask_lfsr
  import cipher_share_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] state
);

  // An all-zero state would lock the LFSR, so a zero seed becomes 1
  localparam logic [31:0] INIT = (SEED == 32'h0) ? 32'h1 : SEED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_TAPS : 32'h0);
  end

endmodule

// File: rtl/cipher_share_driver.sv
// Splits plaintext/key into two Boolean shares for Cipher and recombines its output.
//   state   | meaning
//   IDLE    | Cipher held in reset, waiting for start
//   LOAD    | 16 masked byte pairs streamed out, cipher_rst high on byte 0
//   WAIT    | waiting for Done, bounded by TIMEOUT
//   COLLECT | bytes 1..15 recombined, then ciphertext published
module cipher_share_driver
  import cipher_share_pkg::*;
#(
  parameter int          TIMEOUT = 1024,
  parameter logic [31:0] SEED    = DEFAULT_SEED
) (
  input logic            clk,
  input logic            rst,
  cipher_share_driver_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state, state_nx;
  logic [3:0]     byte_cnt, byte_cnt_nx;
  logic [CW-1:0]  wait_cnt, wait_cnt_nx;
  logic [127:0]   pt_sr, pt_sr_nx;
  logic [127:0]   key_sr, key_sr_nx;
  logic [127:0]   col_sr, col_sr_nx;
  logic [127:0]   ct_q, ct_nx;
  logic [7:0]     in1_q, in1_nx, in2_q, in2_nx;
  logic [7:0]     k1_q, k1_nx, k2_q, k2_nx;
  logic           crst_q, crst_nx;
  logic           ct_valid_q, ct_valid_nx;
  logic           error_q, error_nx;
  logic [31:0]    lfsr;

  mask_lfsr #(.SEED(SEED)) u_mask_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      wait_cnt   <= '0;
      pt_sr      <= '0;
      key_sr     <= '0;
      col_sr     <= '0;
      ct_q       <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      k1_q       <= '0;
      k2_q       <= '0;
      crst_q     <= 1'b1;
      ct_valid_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state      <= state_nx;
      byte_cnt   <= byte_cnt_nx;
      wait_cnt   <= wait_cnt_nx;
      pt_sr      <= pt_sr_nx;
      key_sr     <= key_sr_nx;
      col_sr     <= col_sr_nx;
      ct_q       <= ct_nx;
      in1_q      <= in1_nx;
      in2_q      <= in2_nx;
      k1_q       <= k1_nx;
      k2_q       <= k2_nx;
      crst_q     <= crst_nx;
      ct_valid_q <= ct_valid_nx;
      error_q    <= error_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    byte_cnt_nx = byte_cnt;
    wait_cnt_nx = wait_cnt;
    pt_sr_nx    = pt_sr;
    key_sr_nx   = key_sr;
    col_sr_nx   = col_sr;
    ct_nx       = ct_q;
    in1_nx      = in1_q;
    in2_nx      = in2_q;
    k1_nx       = k1_q;
    k2_nx       = k2_q;
    crst_nx     = crst_q;
    ct_valid_nx = 1'b0;
    error_nx    = 1'b0;

    case (state)
      IDLE: begin
        crst_nx = 1'b1;
        if (bus.start) begin
          pt_sr_nx    = bus.plaintext;
          key_sr_nx   = bus.key;
          byte_cnt_nx = '0;
          state_nx    = LOAD;
        end
      end
      LOAD: begin
        // Both shares come from the same edge so no port ever carries a clear byte
        in2_nx      = lfsr[7:0];
        in1_nx      = pt_sr[127:120] ^ lfsr[7:0];
        k2_nx       = lfsr[15:8];
        k1_nx       = key_sr[127:120] ^ lfsr[15:8];
        pt_sr_nx    = {pt_sr[119:0], 8'h00};
        key_sr_nx   = {key_sr[119:0], 8'h00};
        crst_nx     = (byte_cnt == 4'd0);
        byte_cnt_nx = byte_cnt + 4'd1;
        if (byte_cnt == 4'(NUM_BYTES - 1)) begin
          state_nx    = WAIT;
          wait_cnt_nx = '0;
        end
      end
      WAIT: begin
        crst_nx = 1'b0;
        if (bus.Done) begin
          col_sr_nx   = {col_sr[119:0], bus.output1 ^ bus.output2};
          byte_cnt_nx = 4'd1;
          state_nx    = COLLECT;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          error_nx = 1'b1;
          crst_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          wait_cnt_nx = wait_cnt + CW'(1);
        end
      end
      COLLECT: begin
        crst_nx = 1'b0;
        // byte_cnt wraps 15 -> 0; the zero pass publishes the assembled block
        if (byte_cnt != 4'd0) begin
          col_sr_nx   = {col_sr[119:0], bus.output1 ^ bus.output2};
          byte_cnt_nx = byte_cnt + 4'd1;
        end else begin
          ct_nx       = col_sr;
          ct_valid_nx = 1'b1;
          crst_nx     = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy       = (state != IDLE);
  assign bus.ct_valid   = ct_valid_q;
  assign bus.ciphertext = ct_q;
  assign bus.error      = error_q;
  assign bus.cipher_rst = crst_q;
  assign bus.input1     = in1_q;
  assign bus.input2     = in2_q;
  assign bus.key1       = k1_q;
  assign bus.key2       = k2_q;

endmodule

// File: tb/tb_cipher_share_driver.sv
// Directed bench for cipher_share_driver with a stub Cipher returning masked FIPS-197 bytes.
module tb_cipher_share_driver;

  localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lfsr0_state;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  cipher_share_driver_if bus();

  cipher_share_driver #(.TIMEOUT(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mask_lfsr #(.SEED(32'h0)) u_lfsr0 (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr0_state)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.Done      = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
    bus.output1   = '0;
    bus.output2   = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Issues start and follows the 16 LOAD edges, checking the recombined shares.
  task automatic drive_load(input logic [127:0] pt, input logic [127:0] k,
                            input bit hold_start, input int done_at, output bit varied);
    logic [7:0] first_mask;
    logic       exp_crst;
    first_mask    = '0;
    varied        = 1'b0;
    bus.plaintext = pt;
    bus.key       = k;
    bus.start     = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.ct_valid !== 1'b0)
      $display("FAIL start_accept: busy=%b ct_valid=%b required busy=1 ct_valid=0", bus.busy, bus.ct_valid);
    if (!hold_start) bus.start = 1'b0;
    bus.plaintext = ~pt;
    bus.key       = ~k;
    for (int i = 0; i < 16; i++) begin
      bus.Done = (i == done_at);
      tick();
      exp_crst = (i == 0);
      checks++;
      if ((bus.input1 ^ bus.input2) !== pt[127-8*i -: 8]) begin
        errors++;
        $display("FAIL pt_share[%0d]: got %h required %h", i, bus.input1 ^ bus.input2, pt[127-8*i -: 8]);
      end
      checks++;
      if ((bus.key1 ^ bus.key2) !== k[127-8*i -: 8]) begin
        errors++;
        $display("FAIL key_share[%0d]: got %h required %h", i, bus.key1 ^ bus.key2, k[127-8*i -: 8]);
      end
      checks++;
      if (bus.cipher_rst !== exp_crst || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL load_ctrl[%0d]: cipher_rst=%b busy=%b required cipher_rst=%b busy=1",
                 i, bus.cipher_rst, bus.busy, exp_crst);
      end
      if (i == 0) first_mask = bus.input2;
      else if (bus.input2 !== first_mask) varied = 1'b1;
    end
    bus.Done = 1'b0;
  endtask

  // Stub Cipher: Done after 'delay' idle WAIT cycles, then 16 masked output bytes.
  task automatic drive_collect(input logic [127:0] ct, input int delay, input bit hold_done);
    logic [7:0] m;
    for (int w = 0; w < delay; w++) begin
      bus.Done    = 1'b0;
      bus.output1 = 8'h5a;
      bus.output2 = 8'h00;
      tick();
      checks++;
      if (bus.busy !== 1'b1 || bus.error !== 1'b0 || bus.cipher_rst !== 1'b0) begin
        errors++;
        $display("FAIL wait_state[%0d]: busy=%b error=%b cipher_rst=%b required 1/0/0",
                 w, bus.busy, bus.error, bus.cipher_rst);
      end
    end
    for (int b = 0; b < 16; b++) begin
      m           = 8'($urandom_range(0, 255));
      bus.output2 = m;
      bus.output1 = ct[127-8*b -: 8] ^ m;
      bus.Done    = (b == 0) || hold_done;
      tick();
      checks++;
      if (bus.ct_valid !== 1'b0 || bus.busy !== 1'b1 || bus.cipher_rst !== 1'b0) begin
        errors++;
        $display("FAIL collect[%0d]: ct_valid=%b busy=%b cipher_rst=%b required 0/1/0",
                 b, bus.ct_valid, bus.busy, bus.cipher_rst);
      end
    end
    bus.Done    = 1'b0;
    bus.output1 = '0;
    bus.output2 = '0;
    tick();
    checks++;
    if (bus.ct_valid !== 1'b1 || bus.busy !== 1'b0 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL complete: ct_valid=%b busy=%b error=%b required 1/0/0", bus.ct_valid, bus.busy, bus.error);
    end
    checks++;
    if (bus.ciphertext !== ct) begin
      errors++;
      $display("FAIL ciphertext: got %h required %h", bus.ciphertext, ct);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.Done  = 1'b0;
    #3;
    checks++;
    if (bus.busy !== 1'b0 || bus.ct_valid !== 1'b0 || bus.error !== 1'b0 || bus.ciphertext !== 128'h0) begin
      errors++;
      $display("FAIL reset_status: busy=%b ct_valid=%b error=%b ct=%h required all 0",
               bus.busy, bus.ct_valid, bus.error, bus.ciphertext);
    end
    checks++;
    if (bus.cipher_rst !== 1'b1 || {bus.input1, bus.input2, bus.key1, bus.key2} !== 32'h0) begin
      errors++;
      $display("FAIL reset_shares: cipher_rst=%b shares=%h required 1 and 00000000",
               bus.cipher_rst, {bus.input1, bus.input2, bus.key1, bus.key2});
    end
    do_reset();
    bus.Done = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.cipher_rst !== 1'b1) begin
      errors++;
      $display("FAIL idle_done_ignored: busy=%b cipher_rst=%b required 0/1", bus.busy, bus.cipher_rst);
    end
    bus.Done = 1'b0;
  endtask

  task automatic test_seed_zero();
    bit hit_zero;
    rst = 1'b1;
    #2;
    checks++;
    if (lfsr0_state !== 32'h1) begin
      errors++;
      $display("FAIL seed_zero_init: got %h required 00000001", lfsr0_state);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (lfsr0_state !== 32'h8020_0003) begin
      errors++;
      $display("FAIL lfsr_step1: got %h required 80200003", lfsr0_state);
    end
    tick();
    checks++;
    if (lfsr0_state !== 32'hC030_0002) begin
      errors++;
      $display("FAIL lfsr_step2: got %h required c0300002", lfsr0_state);
    end
    tick();
    checks++;
    if (lfsr0_state !== 32'h6018_0001) begin
      errors++;
      $display("FAIL lfsr_step3: got %h required 60180001", lfsr0_state);
    end
    hit_zero = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      tick();
      if (lfsr0_state == 32'h0) hit_zero = 1'b1;
    end
    checks++;
    if (hit_zero) begin
      errors++;
      $display("FAIL lfsr_nonzero: reached 0 required never 0");
    end
  endtask

  task automatic test_fips();
    bit varied;
    do_reset();
    drive_load(PT, KEY, 1'b0, -1, varied);
    checks++;
    if (!varied) begin
      errors++;
      $display("FAIL mask_varies: input2 constant over LOAD required non-constant");
    end
    drive_collect(CT, 3, 1'b1);
  endtask

  task automatic test_timeout();
    bit varied;
    drive_load(PT2, K2, 1'b0, -1, varied);
    bus.Done = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    checks++;
    if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: error=%b busy=%b required 0/1 at cycle 35", bus.error, bus.busy);
    end
    tick();
    checks++;
    if (bus.error !== 1'b1 || bus.busy !== 1'b0 || bus.ct_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: error=%b busy=%b ct_valid=%b required 1/0/0 at cycle 36",
               bus.error, bus.busy, bus.ct_valid);
    end
    checks++;
    if (bus.ciphertext !== CT || bus.cipher_rst !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold: ct=%h cipher_rst=%b required %h and 1", bus.ciphertext, bus.cipher_rst, CT);
    end
    tick();
    checks++;
    if (bus.error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_width: error=%b required 0", bus.error);
    end
  endtask

  task automatic test_back_to_back();
    bit varied;
    drive_load(PT2, K2, 1'b1, 15, varied);
    drive_collect(CT2, 2, 1'b0);
    // start is still high: the next edge must open a new run straight away
    drive_load(PT, KEY, 1'b0, -1, varied);
    drive_collect(CT, 0, 1'b0);
    tick();
    checks++;
    if (bus.ct_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: ct_valid=%b busy=%b required 0/0", bus.ct_valid, bus.busy);
    end
  endtask

  task automatic test_rst_mid();
    bit         varied;
    bit         saw_valid;
    logic [7:0] m;
    drive_load(PT2, K2, 1'b0, -1, varied);
    for (int b = 0; b < 8; b++) begin
      m           = 8'($urandom_range(0, 255));
      bus.output2 = m;
      bus.output1 = CT2[127-8*b -: 8] ^ m;
      bus.Done    = 1'b1;
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.cipher_rst !== 1'b1 || bus.busy !== 1'b0 || bus.ct_valid !== 1'b0 || bus.ciphertext !== 128'h0) begin
      errors++;
      $display("FAIL rst_mid_status: cipher_rst=%b busy=%b ct_valid=%b ct=%h required 1/0/0/0",
               bus.cipher_rst, bus.busy, bus.ct_valid, bus.ciphertext);
    end
    checks++;
    if ({bus.input1, bus.input2, bus.key1, bus.key2} !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_shares: got %h required 00000000", {bus.input1, bus.input2, bus.key1, bus.key2});
    end
    bus.Done = 1'b0;
    tick();
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ct_valid !== 1'b0 || bus.busy !== 1'b0) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid) begin
      errors++;
      $display("FAIL rst_mid_quiet: activity after reset required none");
    end
    drive_load(PT, KEY, 1'b0, -1, varied);
    drive_collect(CT, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_seed_zero();
    test_fips();
    test_timeout();
    test_back_to_back();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
